// File: rtl/sync_pkg.sv
// Shared types and constants for the receive-side data capture path.
// The FSM encoding is fixed so that the state can be probed by other blocks.
package sync_pkg;

  // Width of the settle down-counter; bounds SETTLE_CYCLES to 0..15.
  localparam int SETTLE_CNT_W = 4;
  localparam int SETTLE_MAX   = 15;

  typedef logic [SETTLE_CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_ZERO = {SETTLE_CNT_W{1'b0}};
  localparam cnt_t CNT_ONE  = {{(SETTLE_CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    HOLD   = 2'b10
  } state_e;

  // Counter load value for a given settle interval. The counter holds the
  // number of remaining SETTLE cycles minus one, so the capture happens on
  // the edge at which it reads zero. Out-of-range requests saturate.
  function automatic cnt_t settle_load(input int unsigned cycles);
    cnt_t load;
    if (cycles == 32'd0) begin
      load = CNT_ZERO;
    end else if (cycles > 32'(SETTLE_MAX)) begin
      load = cnt_t'(SETTLE_MAX - 1);
    end else begin
      load = cnt_t'(cycles - 32'd1);
    end
    return load;
  endfunction

endpackage

// File: rtl/data_sync_capture_if.sv
// Handshake/data bundle between an enable-qualified source bus and the
// capture block. The slave side is the capture block itself.
interface data_sync_capture_if #(
  parameter int BUS_WIDTH = 8
);

  logic                 EN_SYNC;
  logic [BUS_WIDTH-1:0] UNSYNC_BUS;
  logic                 READY;
  logic [BUS_WIDTH-1:0] SYNC_BUS;
  logic                 VALID;
  logic                 ENABLE_PULSE;
  logic                 BUSY;
  logic                 OVERRUN;

  // Producer/consumer side: drives the enable, raw bus and ready.
  modport master (
    output EN_SYNC,
    output UNSYNC_BUS,
    output READY,
    input  SYNC_BUS,
    input  VALID,
    input  ENABLE_PULSE,
    input  BUSY,
    input  OVERRUN
  );

  // Capture block side.
  modport slave (
    input  EN_SYNC,
    input  UNSYNC_BUS,
    input  READY,
    output SYNC_BUS,
    output VALID,
    output ENABLE_PULSE,
    output BUSY,
    output OVERRUN
  );

endinterface

// File: rtl/data_sync_capture_chk.sv
// Protocol invariants of data_sync_capture, observed from its ports.
module data_sync_capture_chk (
  input logic clk_i,
  input logic rst_i,
  input logic valid_i,
  input logic pulse_i,
  input logic busy_i,
  input logic overrun_i
);

  // A capture pulse always coincides with a presented word.
  a_pulse_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    pulse_i |-> valid_i);

  // The capture pulse never lasts more than one cycle.
  a_pulse_single: assert property (@(posedge clk_i) disable iff (rst_i)
    pulse_i |=> !pulse_i);

  // A presented word implies the block reports itself busy.
  a_valid_busy: assert property (@(posedge clk_i) disable iff (rst_i)
    valid_i |-> busy_i);

  // Overrun is sticky until reset.
  a_overrun_sticky: assert property (@(posedge clk_i) disable iff (rst_i)
    overrun_i |=> overrun_i);

endmodule

// File: rtl/data_sync_capture_edge_detect.sv
// Rising-edge detector for a level that is already in the clk_i domain.
// rise_o is combinational from the live level and the registered copy, so
// it is high during the cycle before the first edge that samples the level
// high; the consumer acts on that same edge.
module edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic rise_o
);

  logic en_q;

  // Register the level every cycle so the next cycle can compare against it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q <= 1'b0;
    end else begin
      en_q <= level_i;
    end
  end

  assign rise_o = level_i & ~en_q;

endmodule

// File: rtl/data_sync_capture.sv
// Receive-side capture of a source-domain bus qualified by a synchronized
// enable level. On a rising enable the block waits SETTLE_CYCLES, samples
// the (by then stable) raw bus, and offers it with VALID/READY. A capture
// also produces a one-cycle ENABLE_PULSE. A rising enable that arrives
// while a word is still unaccepted is dropped and flagged in OVERRUN.
module data_sync_capture
  import sync_pkg::*;
#(
  parameter int BUS_WIDTH     = 8,
  parameter int SETTLE_CYCLES = 1   // 0..15
) (
  input logic               CLK,
  input logic               RST,
  data_sync_capture_if.slave bus
);

  localparam bit   NO_SETTLE   = (SETTLE_CYCLES == 0);
  localparam cnt_t SETTLE_LOAD = settle_load(SETTLE_CYCLES);

  state_e               state_q, state_d;
  cnt_t                 cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] sync_bus_q, sync_bus_d;
  logic                 valid_q, valid_d;
  logic                 pulse_q, pulse_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;

  logic                 rise_s;
  logic                 start_s;
  logic                 capture_s;

  edge_detect u_edge (
    .clk_i   (CLK),
    .rst_i   (RST),
    .level_i (bus.EN_SYNC),
    .rise_o  (rise_s)
  );

  // State, counter and all outputs are registered; reset clears everything,
  // including a pending word and the sticky overrun flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= CNT_ZERO;
      sync_bus_q <= {BUS_WIDTH{1'b0}};
      valid_q    <= 1'b0;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sync_bus_q <= sync_bus_d;
      valid_q    <= valid_d;
      pulse_q    <= pulse_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next-state, counter, capture and flag logic. A new start (from IDLE, or
  // from HOLD when the old word is accepted in the same cycle) either
  // captures immediately or enters SETTLE with the counter loaded.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sync_bus_d = sync_bus_q;
    overrun_d  = overrun_q;
    start_s    = 1'b0;
    capture_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise_s) begin
          start_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      SETTLE: begin
        // Enable dropping during the wait means the source withdrew the
        // word before it was guaranteed stable: abandon silently.
        if (!bus.EN_SYNC) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_ZERO) begin
          capture_s = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      HOLD: begin
        if (bus.READY) begin
          if (rise_s) begin
            start_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (rise_s) begin
            overrun_d = 1'b1;
          end else begin
            overrun_d = overrun_q;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (start_s) begin
      if (NO_SETTLE) begin
        capture_s = 1'b1;
      end else begin
        cnt_d   = SETTLE_LOAD;
        state_d = SETTLE;
      end
    end else begin
      cnt_d = cnt_d;
    end

    if (capture_s) begin
      state_d    = HOLD;
      sync_bus_d = bus.UNSYNC_BUS;
    end else begin
      sync_bus_d = sync_bus_d;
    end
  end

  // Output flags derived from the next state so they are registered
  // alongside it and line up with the captured word.
  always_comb begin
    valid_d = (state_d == HOLD);
    busy_d  = (state_d != IDLE);
    pulse_d = capture_s;
  end

  assign bus.SYNC_BUS     = sync_bus_q;
  assign bus.VALID        = valid_q;
  assign bus.ENABLE_PULSE = pulse_q;
  assign bus.BUSY         = busy_q;
  assign bus.OVERRUN      = overrun_q;

endmodule

// File: tb/tb_data_sync_capture.sv
// Scoreboard bench for data_sync_capture. Four instances with settle
// intervals 0, 1, 3 and 2 are driven one at a time by directed sequences.
// Expected words are queued when stimulus is issued; a negedge monitor pops
// and compares them whenever a word is accepted (VALID && READY).
module tb_data_sync_capture;

  localparam int N  = 4;
  localparam int BW = 8;
  // Settle interval per instance (index 0 is the LSB nibble): 0, 1, 3, 2.
  localparam logic [N-1:0][3:0] SET = {4'd2, 4'd3, 4'd1, 4'd0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]         en_r;
  logic [N-1:0]         rdy_r;
  logic [N-1:0][BW-1:0] din_r;
  logic [N-1:0]         valid_s;
  logic [N-1:0]         pulse_s;
  logic [N-1:0]         busy_s;
  logic [N-1:0]         ovr_s;
  logic [N-1:0][BW-1:0] dout_s;

  int vectors     = 0;
  int miscompares = 0;
  int pulse_cnt [N];
  logic [BW-1:0] exp_q [N][$];

  for (genvar g = 0; g < N; g++) begin : g_dut
    data_sync_capture_if #(.BUS_WIDTH(BW)) ifc ();

    assign ifc.EN_SYNC    = en_r[g];
    assign ifc.UNSYNC_BUS = din_r[g];
    assign ifc.READY      = rdy_r[g];
    assign valid_s[g]     = ifc.VALID;
    assign pulse_s[g]     = ifc.ENABLE_PULSE;
    assign busy_s[g]      = ifc.BUSY;
    assign ovr_s[g]       = ifc.OVERRUN;
    assign dout_s[g]      = ifc.SYNC_BUS;

    data_sync_capture #(
      .BUS_WIDTH     (BW),
      .SETTLE_CYCLES (int'(SET[g]))
    ) u_dut (
      .CLK (clk),
      .RST (rst),
      .bus (ifc)
    );

    data_sync_capture_chk u_chk (
      .clk_i     (clk),
      .rst_i     (rst),
      .valid_i   (ifc.VALID),
      .pulse_i   (ifc.ENABLE_PULSE),
      .busy_i    (ifc.BUSY),
      .overrun_i (ifc.OVERRUN)
    );
  end

  // Monitor: count pulses and score every accepted word against the queue.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (pulse_s[i]) pulse_cnt[i]++;
      if (!rst && valid_s[i] && rdy_r[i]) begin
        vectors++;
        if (exp_q[i].size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected[%0d]: got 0x%02h, expected no word", i, dout_s[i]);
        end else begin
          logic [BW-1:0] exp_w;
          exp_w = exp_q[i].pop_front();
          if (dout_s[i] !== exp_w) begin
            miscompares++;
            $display("FAIL sb_word[%0d]: got 0x%02h, expected 0x%02h", i, dout_s[i], exp_w);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic chk_state(input int i, input string tag, input logic v, input logic p,
                           input logic b, input logic o, input logic [BW-1:0] d);
    chk($sformatf("%s.valid[%0d]", tag, i), 32'(valid_s[i]), 32'(v));
    chk($sformatf("%s.pulse[%0d]", tag, i), 32'(pulse_s[i]), 32'(p));
    chk($sformatf("%s.busy[%0d]",  tag, i), 32'(busy_s[i]),  32'(b));
    chk($sformatf("%s.ovr[%0d]",   tag, i), 32'(ovr_s[i]),   32'(o));
    chk($sformatf("%s.bus[%0d]",   tag, i), 32'(dout_s[i]),  32'(d));
  endtask

  initial begin
    int widths [12] = '{1, 2, 3, 4, 2, 5, 3, 1, 20, 6, 2, 3};
    int exp_cap3;

    en_r  = '0;
    rdy_r = '0;
    din_r = '0;
    for (int i = 0; i < N; i++) pulse_cnt[i] = 0;

    // Reset state of every instance.
    step(2);
    for (int i = 0; i < N; i++) chk_state(i, "reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;

    // Instance 2 (settle 3): reset mid-SETTLE, then the still-high enable
    // restarts; reset mid-HOLD loses the word; the next start captures.
    din_r[2] = 8'h99; rdy_r[2] = 1'b0; en_r[2] = 1'b1;
    step(1); chk_state(2, "pre_rst_settle", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    rst = 1'b1;
    step(1); chk_state(2, "rst_settle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    step(3); chk_state(2, "resettle", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    step(1); chk_state(2, "cap_99", 1'b1, 1'b1, 1'b1, 1'b0, 8'h99);
    rst = 1'b1;
    step(1); chk_state(2, "rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0; din_r[2] = 8'h66; exp_q[2].push_back(8'h66);
    step(3); chk_state(2, "resettle2", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    step(1); chk_state(2, "cap_66", 1'b1, 1'b1, 1'b1, 1'b0, 8'h66);
    rdy_r[2] = 1'b1;
    step(1); chk_state(2, "acc_66", 1'b0, 1'b0, 1'b0, 1'b0, 8'h66);
    en_r[2] = 1'b0;
    step(2);

    // Instance 1 (settle 1): basic capture of 0xA5 with READY high.
    din_r[1] = 8'hA5; rdy_r[1] = 1'b1; exp_q[1].push_back(8'hA5); en_r[1] = 1'b1;
    step(1); chk_state(1, "a5_k", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    step(1); chk_state(1, "a5_cap", 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5);
    step(1); chk_state(1, "a5_acc", 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
    en_r[1] = 1'b0;
    step(1);

    // Instance 2 (settle 3): enable high two cycles only -> aborted.
    din_r[2] = 8'h5A; en_r[2] = 1'b1;
    step(1); chk_state(2, "short_k", 1'b0, 1'b0, 1'b1, 1'b0, 8'h66);
    step(1); chk_state(2, "short_k1", 1'b0, 1'b0, 1'b1, 1'b0, 8'h66);
    en_r[2] = 1'b0;
    step(1); chk_state(2, "short_abort", 1'b0, 1'b0, 1'b0, 1'b0, 8'h66);
    step(3); chk_state(2, "short_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h66);

    // Instance 1: hold 0x3C unaccepted, second rise with 0x77 is dropped.
    rdy_r[1] = 1'b0; din_r[1] = 8'h3C; exp_q[1].push_back(8'h3C); en_r[1] = 1'b1;
    step(2); chk_state(1, "cap_3c", 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C);
    en_r[1] = 1'b0;
    step(1); chk_state(1, "hold_3c", 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C);
    en_r[1] = 1'b1; din_r[1] = 8'h77;
    step(1); chk_state(1, "overrun", 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C);
    step(1); chk_state(1, "overrun_hold", 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C);
    en_r[1] = 1'b0; rdy_r[1] = 1'b1;
    step(1); chk_state(1, "acc_3c", 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C);
    exp_q[1].push_back(8'h77); en_r[1] = 1'b1;
    step(2); chk_state(1, "cap_77", 1'b1, 1'b1, 1'b1, 1'b1, 8'h77);
    step(1); chk_state(1, "acc_77", 1'b0, 1'b0, 1'b0, 1'b1, 8'h77);
    en_r[1] = 1'b0;
    step(1);

    // Instance 0 (settle 0): accept and new rise in the same cycle.
    rdy_r[0] = 1'b0; din_r[0] = 8'h11; exp_q[0].push_back(8'h11); en_r[0] = 1'b1;
    step(1); chk_state(0, "cap_11", 1'b1, 1'b1, 1'b1, 1'b0, 8'h11);
    en_r[0] = 1'b0;
    step(1); chk_state(0, "hold_11", 1'b1, 1'b0, 1'b1, 1'b0, 8'h11);
    en_r[0] = 1'b1; din_r[0] = 8'h22; rdy_r[0] = 1'b1; exp_q[0].push_back(8'h22);
    step(1); chk_state(0, "b2b_22", 1'b1, 1'b1, 1'b1, 1'b0, 8'h22);
    en_r[0] = 1'b0;
    step(1); chk_state(0, "acc_22", 1'b0, 1'b0, 1'b0, 1'b0, 8'h22);

    // Instance 3 (settle 2): table of enable widths, READY always high.
    // Only widths of at least 3 cycles are captured.
    rdy_r[3] = 1'b1;
    exp_cap3 = 0;
    for (int k = 0; k < 12; k++) begin
      din_r[3] = 8'(8'h40 + k);
      if (widths[k] >= 3) begin
        exp_q[3].push_back(8'(8'h40 + k));
        exp_cap3++;
      end
      en_r[3] = 1'b1;
      step(widths[k]);
      en_r[3] = 1'b0;
      step(3);
    end

    step(3);
    chk("pulses[0]", 32'(pulse_cnt[0]), 32'd2);
    chk("pulses[1]", 32'(pulse_cnt[1]), 32'd3);
    chk("pulses[2]", 32'(pulse_cnt[2]), 32'd2);
    chk("pulses[3]", 32'(pulse_cnt[3]), 32'(exp_cap3));
    chk("pulses[3]_table", 32'(exp_cap3), 32'd7);
    chk("ovr_end[0]", 32'(ovr_s[0]), 32'd0);
    chk("ovr_end[1]", 32'(ovr_s[1]), 32'd1);
    chk("ovr_end[2]", 32'(ovr_s[2]), 32'd0);
    chk("ovr_end[3]", 32'(ovr_s[3]), 32'd0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("sb_left[%0d]", i), 32'(exp_q[i].size()), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
